// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: state, opcode, alu_op and imm_sel encodings shared by the multicycle controller.
package riscv_ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;
  typedef enum logic [2:0] {C_ILL, C_R, C_LOAD, C_STORE, C_BRANCH} cls_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] IMM_I     = 2'b00;
  localparam logic [1:0] IMM_S     = 2'b01;
  localparam logic [1:0] IMM_B     = 2'b10;
  localparam logic [1:0] IMM_NONE  = 2'b11;
  function automatic cls_t classify(input logic [6:0] op);
    return op == OP_R ? C_R : op == OP_LOAD ? C_LOAD : op == OP_STORE ? C_STORE :
           op == OP_BRANCH ? C_BRANCH : C_ILL;
  endfunction
  function automatic logic [1:0] imm_of(input cls_t c);
    return c == C_LOAD ? IMM_I : c == C_STORE ? IMM_S : c == C_BRANCH ? IMM_B : IMM_NONE;
  endfunction
endpackage

// File: rtl/ctrl_timeout_counter.sv
// ctrl_timeout_counter: counts consecutive stalled cycles; expired flags the stall cycle that hits the limit.
module ctrl_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (count_en) count <= count + 1'b1;
  // the edge ending this cycle would bring count to TIMEOUT_CYCLES
  assign expired = count_en && count == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait timeout.
// Define CTRL_ILLEGAL_TRAP_EN to fault on illegal opcodes; otherwise they execute as NOPs.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch_taken,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [1:0] imm_sel,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       fault
);
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = FAULT;
`else
  localparam state_t ILL_NEXT = FETCH;
`endif
  state_t state;
  cls_t cls_q, cls_d;
  logic [1:0] imm_q;
  logic waiting, expired;
  assign cls_d = classify(opcode);
  assign waiting = state == FETCH || state == MEM;
  ctrl_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst_n(rst_n),
    .count_en(waiting && !mem_ready),
    .clear(!waiting || mem_ready),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      cls_q <= C_ILL;
      imm_q <= IMM_NONE;
    end else begin
      case (state)
        FETCH:  state <= mem_ready ? DECODE : expired ? FAULT : FETCH;
        DECODE: begin
          cls_q <= cls_d;
          imm_q <= imm_of(cls_d);
          state <= cls_d == C_ILL ? ILL_NEXT : EXEC;
        end
        EXEC:   state <= cls_q == C_R ? WB : cls_q == C_BRANCH ? FETCH : MEM;
        MEM:    state <= mem_ready ? (cls_q == C_LOAD ? WB : FETCH) : expired ? FAULT : MEM;
        WB:     state <= FETCH;
        default: state <= FAULT;
      endcase
    end
  // reset state is FETCH, so FETCH-driven outputs are gated by rst_n to drop immediately
  assign mem_req      = rst_n && waiting;
  assign mem_read     = rst_n && (state == FETCH || (state == MEM && cls_q == C_LOAD));
  assign mem_write    = rst_n && state == MEM && cls_q == C_STORE;
  assign ir_write     = rst_n && state == FETCH && mem_ready;
  assign pc_write     = rst_n && state == FETCH && mem_ready;
  assign branch_taken = state == EXEC && cls_q == C_BRANCH && zero;
  assign alu_src      = state == EXEC && (cls_q == C_LOAD || cls_q == C_STORE);
  assign alu_op       = state != EXEC ? ALU_ADD : cls_q == C_R ? ALU_FUNCT :
                        cls_q == C_BRANCH ? ALU_SUB : ALU_ADD;
  assign imm_sel      = state == DECODE ? imm_of(cls_d) : state == FAULT ? 2'b00 : imm_q;
  assign reg_write    = state == WB;
  assign mem_to_reg   = state == WB && cls_q == C_LOAD;
  assign fault        = state == FAULT;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_multicycle_controller;
  localparam int TMO = 15;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam int ILL_PH = 5;
`else
  localparam int ILL_PH = 0;
`endif
  logic clk = 0, rst_n, mem_ready, zero;
  logic [6:0] opcode;
  logic mem_req, mem_read, mem_write, ir_write, pc_write, branch_taken, alu_src;
  logic reg_write, mem_to_reg, fault;
  logic [1:0] alu_op, imm_sel;
  logic [13:0] dut_v, exp_v;
  int n_cmp = 0, n_bad = 0;
  int ph = 0, kind = 0, waitc = 0;
  logic [1:0] imm_m = 2'b11;
  logic rq, rd, wr, iw, pw, bt, as, rw, mr, ft;
  logic [1:0] ao, is;

  multicycle_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .branch_taken(branch_taken), .alu_src(alu_src), .alu_op(alu_op),
    .imm_sel(imm_sel), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .fault(fault)
  );

  always #5 clk = ~clk;
  assign dut_v = {mem_req, mem_read, mem_write, ir_write, pc_write, branch_taken, alu_src,
                  alu_op, imm_sel, reg_write, mem_to_reg, fault};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // instruction kind: 0 illegal, 1 R, 2 load, 3 store, 4 branch
  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return 0;
    endcase
  endfunction
  function automatic logic [1:0] imm_for(input int k);
    return k == 2 ? 2'b00 : k == 3 ? 2'b01 : k == 4 ? 2'b10 : 2'b11;
  endfunction

  // phases: 0 fetch, 1 decode, 2 exec, 3 mem, 4 writeback, 5 fault
  always @(negedge clk) begin
    {rq, rd, wr, iw, pw, bt, as, rw, mr, ft} = '0;
    ao = 2'b00;
    is = imm_m;
    if (!rst_n) begin
      ph = 0; waitc = 0; imm_m = 2'b11; is = 2'b11;
    end else begin
      case (ph)
        0: begin rq = 1; rd = 1; iw = mem_ready; pw = mem_ready; end
        1: is = imm_for(kind_of(opcode));
        2: begin
          as = kind == 2 || kind == 3;
          ao = kind == 1 ? 2'b10 : kind == 4 ? 2'b01 : 2'b00;
          bt = kind == 4 && zero;
        end
        3: begin rq = 1; rd = kind == 2; wr = kind == 3; end
        4: begin rw = 1; mr = kind == 2; end
        default: begin ft = 1; is = 2'b00; end
      endcase
    end
    exp_v = {rq, rd, wr, iw, pw, bt, as, ao, is, rw, mr, ft};
    chk("outputs", 32'(dut_v), 32'(exp_v));
    chk("exclusive", 32'({mem_read & mem_write, branch_taken & pc_write}), 32'd0);
    if (rst_n) begin
      if (ph == 0 || ph == 3) begin
        if (mem_ready) begin
          waitc = 0;
          ph = ph == 0 ? 1 : kind == 2 ? 4 : 0;
        end else begin
          waitc++;
          if (waitc == TMO) begin ph = 5; waitc = 0; end
        end
      end else if (ph == 1) begin
        kind = kind_of(opcode);
        imm_m = imm_for(kind);
        ph = kind == 0 ? ILL_PH : 2;
      end else if (ph == 2) ph = kind == 1 ? 4 : kind == 4 ? 0 : 3;
      else if (ph == 4) ph = 0;
    end
  end

  task automatic st(input logic r, input logic z);
    @(posedge clk);
    #2 mem_ready = r; zero = z;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    int n, r, mode;
    rst_n = 0; mem_ready = 0; zero = 0; opcode = 7'b0110011;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_imm_sel", 32'(imm_sel), 3);
    chk("rst_fault", 32'(fault), 0);
    mem_ready = 1;
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("first_fetch_req", 32'(mem_req), 1);
    chk("fetch_ir_write", 32'(ir_write), 1);
    chk("fetch_pc_write", 32'(pc_write), 1);
    st(0, 0); chk("r_dec_imm", 32'(imm_sel), 3); chk("r_dec_req", 32'(mem_req), 0);
    st(0, 0); chk("r_exec_aluop", 32'(alu_op), 2); chk("r_exec_src", 32'(alu_src), 0);
    st(0, 0); chk("r_wb_rw", 32'(reg_write), 1); chk("r_wb_m2r", 32'(mem_to_reg), 0);
    opcode = 7'b0000011;
    st(1, 0); chk("ld_fetch_req", 32'(mem_req), 1); chk("ld_fetch_irw", 32'(ir_write), 1);
    st(0, 0); chk("ld_dec_imm", 32'(imm_sel), 0);
    st(0, 0); chk("ld_exec_src", 32'(alu_src), 1); chk("ld_exec_aluop", 32'(alu_op), 0);
    n = 0;
    repeat (3) begin st(0, 0); n += int'(mem_read); chk("ld_mem_imm", 32'(imm_sel), 0); end
    st(1, 0); n += int'(mem_read);
    chk("ld_mem_read_cycles", 32'(n), 4);
    st(0, 0); chk("ld_wb_m2r", 32'(mem_to_reg), 1); chk("ld_wb_imm", 32'(imm_sel), 0);
    opcode = 7'b1100011;
    st(1, 0);
    st(0, 0); chk("br_dec_imm", 32'(imm_sel), 2);
    st(0, 1); chk("br_taken", 32'(branch_taken), 1); chk("br_pc_write", 32'(pc_write), 0);
    st(1, 0); chk("br_back_fetch", 32'(mem_req), 1);
    st(0, 0);
    st(0, 0); chk("br_not_taken", 32'(branch_taken), 0);
    st(0, 0); chk("tmo_fetch_req", 32'(mem_req), 1);
    repeat (13) st(0, 0);
    st(1, 0); chk("tmo_ready15_irw", 32'(ir_write), 1); chk("tmo_ready15_fault", 32'(fault), 0);
    opcode = 7'b1111111;
    st(0, 0); chk("ill_dec_fault", 32'(fault), 0);
    st(0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_trap_fault", 32'(fault), 1);
`else
    chk("ill_nop_fetch", 32'(mem_req), 1);
    chk("ill_nop_fault", 32'(fault), 0);
`endif
    mem_ready = 0;
    do_reset();
    repeat (14) st(0, 0);
    chk("tmo_c15_fault", 32'(fault), 0);
    st(0, 0); chk("tmo_fault", 32'(fault), 1); chk("tmo_fault_req", 32'(mem_req), 0);
    st(1, 0); chk("tmo_sticky", 32'(fault), 1); chk("tmo_sticky_irw", 32'(ir_write), 0);
    opcode = 7'b0100011; mem_ready = 1;
    do_reset();
    st(0, 0); chk("st_dec_imm", 32'(imm_sel), 1);
    st(0, 0); chk("st_exec_src", 32'(alu_src), 1);
    st(0, 0); chk("st_mem_write", 32'(mem_write), 1); chk("st_mem_read", 32'(mem_read), 0);
    #1 rst_n = 0;
    #1 chk("st_rst_write", 32'(mem_write), 0); chk("st_rst_req", 32'(mem_req), 0);
    chk("st_rst_imm", 32'(imm_sel), 3);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("st_restart_req", 32'(mem_req), 1); chk("st_restart_fault", 32'(fault), 0);
    for (int ep = 0; ep < 12; ep++) begin
      mode = ep % 3;
      do_reset();
      for (int c = 0; c < 250; c++) begin
        @(posedge clk);
        #2;
        r = $urandom_range(0, 5);
        opcode = r == 0 ? 7'b0110011 : r == 1 ? 7'b0000011 : r == 2 ? 7'b0100011 :
                 r == 3 ? 7'b1100011 : r == 4 ? 7'b1111111 : 7'($urandom);
        mem_ready = mode == 0 ? $urandom_range(0, 1) == 1 :
                    $urandom_range(0, mode == 1 ? 19 : 13) == 0;
        zero = $urandom_range(0, 1) == 1;
      end
    end
    @(negedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15, max cycles a memory access may wait on mem_ready before fault.
REQ-002 Ports: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Ports: opcode  in  7  instruction[6:0] from the instruction register; mem_ready  in  1  memory access complete this cycle; zero  in  1  ALU zero flag.
REQ-005 Ports: mem_req  out  1  memory access request; mem_read  out  1; mem_write  out  1; ir_write  out  1  load instruction register; pc_write  out  1  PC <= PC+4; branch_taken  out  1  PC <= branch target.
REQ-006 Ports: alu_src  out  1  0=register, 1=immediate; alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded; imm_sel  out  2  00 I, 01 S, 10 B, 11 none; reg_write  out  1; mem_to_reg  out  1; fault  out  1  sticky timeout/illegal flag.

Function
REQ-007 States SHALL be FETCH, DECODE, EXEC, MEM, WB, FAULT; one state per cycle unless stalled.
REQ-008 FETCH: mem_req=1, mem_read=1; hold until mem_ready=1; in that cycle ir_write=1 and pc_write=1 (Mealy); next DECODE.
REQ-009 DECODE (1 cycle): classify opcode: 0110011 R, 0000011 load, 0100011 store, 1100011 branch, anything else illegal; set imm_sel (R->11, load->00, store->01, branch->10), held constant until next FETCH.
REQ-010 EXEC: R -> alu_src=0, alu_op=10, next WB; load/store -> alu_src=1, alu_op=00, next MEM; branch -> alu_src=0, alu_op=01, branch_taken=zero (same cycle), next FETCH.
REQ-011 MEM: mem_req=1 with mem_read=1 (load) or mem_write=1 (store); hold until mem_ready; then load -> WB, store -> FETCH.
REQ-012 WB: reg_write=1 for exactly one cycle, mem_to_reg=1 for load, 0 for R; next FETCH.
REQ-013 mem_read and mem_write SHALL never be high together; branch_taken and pc_write SHALL never be high together.
REQ-014 Wait counter SHALL count consecutive cycles in FETCH/MEM with mem_ready=0; cleared on mem_ready=1 or state change; at count==TIMEOUT_CYCLES go FAULT.
REQ-015 mem_ready=1 in the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete the access (no fault).
REQ-016 FAULT: fault=1, all other outputs 0, stays until reset.
REQ-017 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); no wrap-around possible.

Reset
REQ-018 rst_n low SHALL immediately force state FETCH, counter 0, imm_sel 11, all other outputs 0, including mid-access.
REQ-019 First rising edge after rst_n release SHALL see mem_req=1 in FETCH.

Configuration
REQ-020 Macro CTRL_ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> FAULT next cycle.
REQ-021 Macro undefined: illegal opcode treated as NOP, DECODE -> FETCH, fault set only by timeout.

Structure
REQ-022 Package riscv_ctrl_pkg SHALL hold the state enum, opcode constants, alu_op and imm_sel encodings.
REQ-023 Wait counter SHALL be sub-module ctrl_timeout_counter (inputs clk, rst_n, count_en, clear; output expired).

Verification
REQ-024 R-type 0110011, mem_ready=1 on first FETCH cycle -> FETCH,DECODE,EXEC(alu_op=10),WB(reg_write=1,mem_to_reg=0), back to FETCH in 4 cycles.
REQ-025 Load 0000011, MEM mem_ready delayed 3 cycles -> mem_read held 4 cycles, WB mem_to_reg=1, imm_sel=00 throughout.
REQ-026 Branch 1100011 with zero=1 -> branch_taken=1 in EXEC, pc_write=0; with zero=0 -> branch_taken=0; both return to FETCH.
REQ-027 mem_ready held 0 in FETCH for 15 cycles -> FAULT, fault=1 sticky; mem_ready=1 exactly on 15th cycle -> no fault.
REQ-028 Opcode 1111111 -> FAULT with CTRL_ILLEGAL_TRAP_EN, FETCH without it.
REQ-029 rst_n pulsed low mid-MEM store -> mem_write drops asynchronously; restart in FETCH, fault=0.
